// File: rtl/seq_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
package seq_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Bits needed to represent a fill level of 0..n inclusive.
  function automatic int fill_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Serial-in / status-out bundle between a bit source and the detector.
interface seq_detect_param_if #(
  parameter int N  = 3,
  parameter int CW = 3
) ();

  logic                                x;
  logic                                en;
  logic [N-1:0]                        pattern;
  logic                                overlap;
  logic                                match;
  logic [CW-1:0]                       count;
  logic [seq_pkg::fill_width(N)-1:0]   fill;

  modport master (
    output x, en, pattern, overlap,
    input  match, count, fill
  );

  modport slave (
    input  x, en, pattern, overlap,
    output match, count, fill
  );

endinterface

// File: rtl/seq_detect_param_match_counter.sv
// Match counter that either wraps modulo 2^CW or sticks at its maximum.
module match_counter
  import seq_pkg::*;
#(
  parameter int CW  = 3,
  parameter int SAT = CNT_WRAP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q, count_d;

  // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (inc) begin
      if (SAT == CNT_SAT && count_q == '1) count_d = count_q;
      else                                 count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector: N-bit history, fill-level FSM, programmable compare.
module seq_detect_param
  import seq_pkg::*;
#(
  parameter int N   = 3,
  parameter int CW  = 3,
  parameter int SAT = CNT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  seq_detect_param_if.slave bus
);

  localparam int FW = fill_width(N);

  localparam logic [FW-1:0] FILL_EMPTY = '0;
  localparam logic [FW-1:0] FILL_FULL  = FW'(N);

  logic [N-1:0]  hist_q, hist_d, next_hist;
  logic [FW-1:0] fill_q, fill_d, next_fill;
  logic          match_q, match_d;
  logic          hit;

  always_comb begin
    next_hist = {hist_q[N-2:0], bus.x};
    next_fill = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    // Fill guard keeps short histories (e.g. zeros after reset) from matching.
    hit       = bus.en && (next_fill == FILL_FULL) && (next_hist == bus.pattern);

    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (bus.en) begin
      hist_d  = next_hist;
      // Non-overlapping mode demands N fresh bits before the next match.
      fill_d  = (hit && !bus.overlap) ? FILL_EMPTY : next_fill;
      match_d = hit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q  <= '0;
      fill_q  <= FILL_EMPTY;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  match_counter #(
    .CW  (CW),
    .SAT (SAT)
  ) u_match_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .count (bus.count)
  );

  assign bus.match = match_q;
  assign bus.fill  = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench: directed vector table, saturate/wrap corners, random vs queue model.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x = 1'b0;
  logic       en = 1'b0;
  logic       overlap = 1'b1;
  logic [2:0] pattern3 = 3'b000;
  logic [4:0] pattern5 = 5'b00000;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_param_if #(.N(3), .CW(3)) if0 ();
  seq_detect_param_if #(.N(3), .CW(2)) if_w ();
  seq_detect_param_if #(.N(3), .CW(2)) if_s ();
  seq_detect_param_if #(.N(5), .CW(4)) if5 ();

  assign if0.x = x;   assign if0.en = en;   assign if0.overlap = overlap;   assign if0.pattern = pattern3;
  assign if_w.x = x;  assign if_w.en = en;  assign if_w.overlap = overlap;  assign if_w.pattern = pattern3;
  assign if_s.x = x;  assign if_s.en = en;  assign if_s.overlap = overlap;  assign if_s.pattern = pattern3;
  assign if5.x = x;   assign if5.en = en;   assign if5.overlap = overlap;   assign if5.pattern = pattern5;

  seq_detect_param #(.N(3), .CW(3), .SAT(0)) dut   (.clk(clk), .reset(reset), .bus(if0));
  seq_detect_param #(.N(3), .CW(2), .SAT(0)) dut_w (.clk(clk), .reset(reset), .bus(if_w));
  seq_detect_param #(.N(3), .CW(2), .SAT(1)) dut_s (.clk(clk), .reset(reset), .bus(if_s));
  seq_detect_param #(.N(5), .CW(4), .SAT(1)) dut5  (.clk(clk), .reset(reset), .bus(if5));

  typedef struct {
    bit       rst;
    bit       en;
    bit       x;
    bit [2:0] pat;
    bit       ovl;
    bit       exp_match;
    bit [2:0] exp_count;
    bit [1:0] exp_fill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit e, bit xb, bit [2:0] p, bit o,
                              bit m, bit [2:0] c, bit [1:0] f);
    vec_t v;
    v.rst = r; v.en = e; v.x = xb; v.pat = p; v.ovl = o;
    v.exp_match = m; v.exp_count = c; v.exp_fill = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the edge; outputs are read 1 ns after the next edge.
  task automatic apply(input bit r, input bit e, input bit xb);
    reset = r; en = e; x = xb;
    @(posedge clk);
    #1;
  endtask

  // Reference model: the stream of bits accepted since the last reset or
  // non-overlapping match, trimmed to the newest N; a match is the newest N
  // bits spelling the pattern.
  bit model_q[4][$];
  int model_cnt[4];
  int n_of[4]   = '{3, 3, 3, 5};
  int cw_of[4]  = '{3, 2, 2, 4};
  int sat_of[4] = '{0, 0, 1, 1};

  task automatic model_step(input int id, input bit r, input bit e, input bit xb,
                            input bit ov, input logic [31:0] pat, output bit m);
    int n;
    bit eq;
    n = n_of[id];
    m = 1'b0;
    if (r) begin
      model_q[id].delete();
      model_cnt[id] = 0;
    end else if (e) begin
      model_q[id].push_back(xb);
      if (model_q[id].size() > n) void'(model_q[id].pop_front());
      if (model_q[id].size() == n) begin
        eq = 1'b1;
        for (int i = 0; i < n; i++)
          if (model_q[id][i] != pat[n-1-i]) eq = 1'b0;
        if (eq) begin
          m = 1'b1;
          model_cnt[id]++;
          if (!ov) model_q[id].delete();
        end
      end
    end
  endtask

  function automatic int exp_count(input int id);
    int maxv;
    maxv = (1 << cw_of[id]) - 1;
    if (sat_of[id] != 0) return (model_cnt[id] > maxv) ? maxv : model_cnt[id];
    return model_cnt[id] % (maxv + 1);
  endfunction

  function automatic logic [31:0] act_match(input int id);
    case (id)
      0: return 32'(if0.match);
      1: return 32'(if_w.match);
      2: return 32'(if_s.match);
      default: return 32'(if5.match);
    endcase
  endfunction

  function automatic logic [31:0] act_count(input int id);
    case (id)
      0: return 32'(if0.count);
      1: return 32'(if_w.count);
      2: return 32'(if_s.count);
      default: return 32'(if5.count);
    endcase
  endfunction

  function automatic logic [31:0] act_fill(input int id);
    case (id)
      0: return 32'(if0.fill);
      1: return 32'(if_w.fill);
      2: return 32'(if_s.fill);
      default: return 32'(if5.fill);
    endcase
  endfunction

  initial begin
    int pulses_w;
    int pulses_s;
    bit m;
    int fill_exp;

    // Directed scenarios run back to back: overlap, non-overlap, mid-stream
    // reset, enable gaps, all-zero pattern with fill guard and reset priority.
    vecs.push_back(mk(1,0,0,3'b101,1, 0,0,0));
    vecs.push_back(mk(0,1,1,3'b101,1, 0,0,1));
    vecs.push_back(mk(0,1,0,3'b101,1, 0,0,2));
    vecs.push_back(mk(0,1,1,3'b101,1, 1,1,3));
    vecs.push_back(mk(0,1,0,3'b101,1, 0,1,3));
    vecs.push_back(mk(0,1,1,3'b101,1, 1,2,3));
    vecs.push_back(mk(1,0,0,3'b101,0, 0,0,0));
    vecs.push_back(mk(0,1,1,3'b101,0, 0,0,1));
    vecs.push_back(mk(0,1,0,3'b101,0, 0,0,2));
    vecs.push_back(mk(0,1,1,3'b101,0, 1,1,0));
    vecs.push_back(mk(0,1,0,3'b101,0, 0,1,1));
    vecs.push_back(mk(0,1,1,3'b101,0, 0,1,2));
    vecs.push_back(mk(1,0,0,3'b101,1, 0,0,0));
    vecs.push_back(mk(0,1,1,3'b101,1, 0,0,1));
    vecs.push_back(mk(0,1,0,3'b101,1, 0,0,2));
    vecs.push_back(mk(1,1,1,3'b101,1, 0,0,0));
    vecs.push_back(mk(0,1,1,3'b101,1, 0,0,1));
    vecs.push_back(mk(1,0,0,3'b101,1, 0,0,0));
    vecs.push_back(mk(0,1,1,3'b101,1, 0,0,1));
    vecs.push_back(mk(0,0,0,3'b101,1, 0,0,1));
    vecs.push_back(mk(0,0,0,3'b101,1, 0,0,1));
    vecs.push_back(mk(0,1,0,3'b101,1, 0,0,2));
    vecs.push_back(mk(0,1,1,3'b101,1, 1,1,3));
    vecs.push_back(mk(0,0,1,3'b101,1, 0,1,3));
    vecs.push_back(mk(1,0,0,3'b000,1, 0,0,0));
    vecs.push_back(mk(0,1,0,3'b000,1, 0,0,1));
    vecs.push_back(mk(0,1,0,3'b000,1, 0,0,2));
    vecs.push_back(mk(0,1,0,3'b000,1, 1,1,3));
    vecs.push_back(mk(1,0,0,3'b000,1, 0,0,0));
    vecs.push_back(mk(0,1,0,3'b000,1, 0,0,1));
    vecs.push_back(mk(0,1,0,3'b000,1, 0,0,2));
    vecs.push_back(mk(1,1,0,3'b000,1, 0,0,0));

    foreach (vecs[i]) begin
      pattern3 = vecs[i].pat;
      overlap  = vecs[i].ovl;
      apply(vecs[i].rst, vecs[i].en, vecs[i].x);
      check($sformatf("vec%0d.match", i), 32'(if0.match), 32'(vecs[i].exp_match));
      check($sformatf("vec%0d.count", i), 32'(if0.count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d.fill",  i), 32'(if0.fill),  32'(vecs[i].exp_fill));
    end

    // Counter corner: six 1s against 111 give four matches on a 2-bit counter.
    pattern3 = 3'b111;
    overlap  = 1'b1;
    apply(1, 0, 0);
    pulses_w = 0;
    pulses_s = 0;
    for (int i = 1; i <= 6; i++) begin
      apply(0, 1, 1);
      if (if_w.match === 1'b1) pulses_w++;
      if (if_s.match === 1'b1) pulses_s++;
      check($sformatf("sat_bit%0d.match_w", i), 32'(if_w.match), (i >= 3) ? 32'd1 : 32'd0);
      check($sformatf("sat_bit%0d.match_s", i), 32'(if_s.match), (i >= 3) ? 32'd1 : 32'd0);
    end
    check("wrap.final_count", 32'(if_w.count), 32'd0);
    check("sat.final_count",  32'(if_s.count), 32'd3);
    check("wrap.pulses", 32'(pulses_w), 32'd4);
    check("sat.pulses",  32'(pulses_s), 32'd4);
    apply(0, 0, 1);
    check("sat.match_drop", 32'(if_s.match), 32'd0);

    // Random traffic against the queue model on all four instances.
    apply(1, 0, 0);
    for (int id = 0; id < 4; id++) begin
      model_q[id].delete();
      model_cnt[id] = 0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      bit r, e, xb;
      r  = ($urandom_range(0, 59) == 0);
      e  = ($urandom_range(0, 3) != 0);
      xb = $urandom_range(0, 1);
      if ($urandom_range(0, 49) == 0) overlap  = $urandom_range(0, 1);
      if ($urandom_range(0, 29) == 0) pattern3 = 3'($urandom);
      if ($urandom_range(0, 99) == 0) pattern5 = 5'($urandom);
      for (int id = 0; id < 4; id++) begin
        model_step(id, r, e, xb, overlap,
                   (id == 3) ? 32'(pattern5) : 32'(pattern3), m);
        if (id == 0) begin
          apply(r, e, xb);
        end
        fill_exp = (model_q[id].size() > n_of[id]) ? n_of[id] : model_q[id].size();
        check($sformatf("rnd%0d.d%0d.match", cyc, id), act_match(id), 32'(m));
        check($sformatf("rnd%0d.d%0d.count", cyc, id), act_count(id), 32'(exp_count(id)));
        check($sformatf("rnd%0d.d%0d.fill",  cyc, id), act_fill(id),  32'(fill_exp));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector, successor to the fixed 3-bit lab FSM.
- Shifts one bit per enabled clock into an N-bit history and compares it against a run-time programmable pattern.
- Pulses a match flag and keeps a running match count, with selectable overlapping or non-overlapping detection.
- Sits on a serial input line; its outputs feed LEDs, the 7-segment display or a downstream controller.

Parameters:
N, 3, pattern length in bits (N >= 2)
CW, 3, match counter width in bits
SAT, 0, counter mode: 0 = wrap modulo 2^CW, 1 = saturate at 2^CW-1

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  synchronous, active-high reset
x  input  1  serial data bit, sampled at rising clk when en=1
en  input  1  shift enable; when 0, the x sample is ignored
pattern  input  N  target pattern; MSB is the oldest bit
overlap  input  1  1 = overlapping detection, 0 = non-overlapping
match  output  1  registered one-cycle pulse per detected pattern
count  output  CW  registered number of matches since reset
fill  output  $clog2(N+1)  number of valid history bits, 0..N

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and has priority over everything else.
- Reset values: history=0, fill=0, match=0, count=0.
- Internal state: history register hist[N-1:0] and fill counter. fill is the visible FSM state: EMPTY (0), FILLING (1..N-1), FULL (N).
- Per rising clk, when reset=0 and en=1:
  - next_hist = {hist[N-2:0], x}
  - next_fill = min(fill+1, N)
  - hit = (next_fill == N) && (next_hist == pattern)
  - If hit: match <= 1; count increments.
  - If hit and overlap=1: hist <= next_hist; fill <= N.
  - If hit and overlap=0: hist <= next_hist; fill <= 0. The next match then needs N fresh bits.
  - If no hit: hist <= next_hist; fill <= next_fill; match <= 0.
- When en=0: hist, fill and count hold; match <= 0. A bit presented while en=0 is never sampled.
- Latency: match is high in the cycle immediately after the edge that sampled the last pattern bit. It is never high two cycles in a row unless consecutive enabled bits each complete a match.
- Fill guard: no match while fewer than N valid bits exist. This covers the all-zero pattern after reset.
- pattern and overlap are read combinationally every enabled cycle. A change takes effect on the next enabled edge; there is no flush and history is kept.
- Counter:
  - SAT=0: 2^CW-1 + 1 wraps to 0.
  - SAT=1: holds at 2^CW-1; match still pulses.
- Reset mid-stream: partial history is discarded; fill restarts from 0 on the next enabled bit.
- Simultaneous reset and en with a matching bit: reset wins, match=0, count=0.

Decomposition:
- Shared package seq_pkg: function fill_width(N) = $clog2(N+1); mode constants CNT_WRAP=0 and CNT_SAT=1.
- One sub-module, match_counter (parameters CW, SAT; ports clk, reset, inc, count). It isolates the wrap/saturate logic.
- Detector core (history, fill FSM, compare) stays in seq_detect_param.

Test Plan:
1. N=3, pattern=101, overlap=1, reset held 1 cycle, then enabled x=1,0,1,0,1 -> match pulses after bits 3 and 5; count=2; fill=3 after bit 3.
2. Same stimulus with overlap=0 -> match only after bit 3; fill=0 after that edge and 2 after bit 5; count=1.
3. pattern=101, x=1,0, then reset=1 for 1 cycle, then x=1 -> no match; fill=1; count=0.
4. pattern=101, en=1 with x=1; en=0 for 2 cycles with x=0; en=1 with x=0,1 -> exactly one match pulse after the final bit; count=1; fill held at 1 during en=0.
5. N=3, CW=2, pattern=111, overlap=1, six enabled x=1 -> matches after bits 3,4,5,6. SAT=0 gives final count=0 (wrapped); SAT=1 gives final count=3; match pulses 4 times in both.
6. pattern=000 right after reset, x=0,0,0 -> no match after bits 1-2 (fill guard); match after bit 3; a simultaneous reset on bit 3 instead gives match=0, count=0.
